// File: rtl/sdes_pkg.sv
// sdes_pkg: FSM state type, SDES permutations, key-schedule shifts and S-boxes
package sdes_pkg;

    typedef enum logic [2:0] {IDLE, KEYGEN, ROUND1, ROUND2, DONE} state_t;

    // S-box entries packed as 2-bit fields, index = row*4 + col, entry 0 at the LSB
    localparam logic [31:0] S0_TAB = {2'd2, 2'd3, 2'd1, 2'd3, 2'd3, 2'd1, 2'd2, 2'd0,
                                      2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd0, 2'd1};
    localparam logic [31:0] S1_TAB = {2'd3, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd0, 2'd3,
                                      2'd3, 2'd1, 2'd0, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};

    function automatic logic [9:0] p10(input logic [9:0] k);
        return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
    endfunction

    function automatic logic [7:0] p8(input logic [9:0] k);
        return {k[4], k[7], k[3], k[6], k[2], k[5], k[0], k[1]};
    endfunction

    function automatic logic [7:0] ip(input logic [7:0] b);
        return {b[6], b[2], b[5], b[7], b[4], b[0], b[3], b[1]};
    endfunction

    function automatic logic [7:0] ip_inv(input logic [7:0] b);
        return {b[4], b[7], b[5], b[3], b[1], b[6], b[0], b[2]};
    endfunction

    function automatic logic [7:0] ep(input logic [3:0] r);
        return {r[0], r[3], r[2], r[1], r[2], r[1], r[0], r[3]};
    endfunction

    function automatic logic [3:0] p4(input logic [3:0] s);
        return {s[2], s[0], s[1], s[3]};
    endfunction

    function automatic logic [4:0] ls1(input logic [4:0] x);
        return {x[3:0], x[4]};
    endfunction

    function automatic logic [4:0] ls3(input logic [4:0] x);
        return {x[1:0], x[4:2]};
    endfunction

    // row = {b1,b4}, column = {b2,b3}
    function automatic logic [1:0] s0(input logic [3:0] x);
        return S0_TAB[{x[3], x[0], x[2], x[1], 1'b0} +: 2];
    endfunction

    function automatic logic [1:0] s1(input logic [3:0] x);
        return S1_TAB[{x[3], x[0], x[2], x[1], 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/sdes_f_func.sv
// sdes_f_func: combinational SDES F-function (EP, subkey XOR, S0/S1, P4)
module sdes_f_func
    import sdes_pkg::*;
(
    input  logic [3:0] r,
    input  logic [7:0] subkey,
    output logic [3:0] f
);

    logic [7:0] x;

    assign x = ep(r) ^ subkey;
    assign f = p4({s0(x[7:4]), s1(x[3:0])});

endmodule

// File: rtl/sdes_round_ctrl.sv
// sdes_round_ctrl: iterative SDES engine sharing one F-function over both rounds
// Optional: define SDES_BLOCK_CNT_EN to add the o_block_cnt result counter.
module sdes_round_ctrl
    import sdes_pkg::*;
#(
    parameter int RESULT_HOLD = 1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_valid,
    output logic       o_ready,
    input  logic       i_decrypt,
    input  logic [9:0] i_key,
    input  logic [7:0] i_block,
    output logic       o_valid,
    input  logic       i_ready,
    output logic [7:0] o_block,
    output logic       o_busy
`ifdef SDES_BLOCK_CNT_EN
    ,
    output logic [15:0] o_block_cnt
`endif
);

    state_t     state;
    logic [9:0] key_r;
    logic [7:0] blk_r;
    logic       dec_r;
    logic [7:0] k1;
    logic [7:0] k2;
    logic [3:0] l;
    logic [3:0] r;
    logic [9:0] pk;
    logic [7:0] sub;
    logic [3:0] f;
    logic       res_done;

    assign o_ready  = state == IDLE;
    assign o_busy   = state != IDLE;
    assign pk       = p10(key_r);
    assign res_done = o_valid && (RESULT_HOLD == 0 || i_ready);

    // Round 1 uses K1 (encrypt) or K2 (decrypt); round 2 uses the other one
    always_comb sub = ((state == ROUND2) ^ dec_r) ? k2 : k1;

    sdes_f_func u_f (
        .r      (r),
        .subkey (sub),
        .f      (f)
    );

    // Controller FSM: accept, key schedule + IP, two Feistel rounds, result hold
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            key_r   <= '0;
            blk_r   <= '0;
            dec_r   <= 1'b0;
            k1      <= '0;
            k2      <= '0;
            l       <= '0;
            r       <= '0;
            o_block <= '0;
            o_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    key_r <= i_key;
                    blk_r <= i_block;
                    dec_r <= i_decrypt;
                    state <= KEYGEN;
                end
                KEYGEN: begin
                    k1     <= p8({ls1(pk[9:5]), ls1(pk[4:0])});
                    k2     <= p8({ls3(pk[9:5]), ls3(pk[4:0])});
                    {l, r} <= ip(blk_r);
                    state  <= ROUND1;
                end
                ROUND1: begin
                    l     <= r;
                    r     <= l ^ f;
                    state <= ROUND2;
                end
                ROUND2: begin
                    o_block <= ip_inv({l ^ f, r});
                    o_valid <= 1'b1;
                    state   <= DONE;
                end
                DONE: if (res_done) begin
                    o_valid <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SDES_BLOCK_CNT_EN
    // Count completed result handshakes, wrapping at 16 bits
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) o_block_cnt <= '0;
        else if (res_done) o_block_cnt <= o_block_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_sdes_round_ctrl.sv
// tb_sdes_round_ctrl: scoreboard bench with a table-driven SDES reference model
module tb_sdes_round_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_valid;
    logic       o_ready;
    logic       i_decrypt;
    logic [9:0] i_key;
    logic [7:0] i_block;
    logic       o_valid;
    logic       i_ready;
    logic [7:0] o_block;
    logic       o_busy;
`ifdef SDES_BLOCK_CNT_EN
    logic [15:0] o_block_cnt;
`endif

    int total = 0;
    int bad = 0;
    int exp_q[$];

    int P10[10] = '{3, 5, 2, 7, 4, 10, 1, 9, 8, 6};
    int P8[10]  = '{6, 3, 7, 4, 8, 5, 10, 9, 0, 0};
    int IP[10]  = '{2, 6, 3, 1, 4, 8, 5, 7, 0, 0};
    int IPI[10] = '{4, 1, 3, 5, 7, 2, 8, 6, 0, 0};
    int EP[10]  = '{4, 1, 2, 3, 2, 3, 4, 1, 0, 0};
    int P4[10]  = '{2, 4, 3, 1, 0, 0, 0, 0, 0, 0};
    int S0[16]  = '{1, 0, 3, 2, 3, 2, 1, 0, 0, 2, 1, 3, 3, 1, 3, 2};
    int S1[16]  = '{0, 1, 2, 3, 2, 0, 1, 3, 3, 0, 1, 0, 2, 1, 0, 3};

    sdes_round_ctrl dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_valid   (i_valid),
        .o_ready   (o_ready),
        .i_decrypt (i_decrypt),
        .i_key     (i_key),
        .i_block   (i_block),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_block   (o_block),
        .o_busy    (o_busy)
`ifdef SDES_BLOCK_CNT_EN
        ,
        .o_block_cnt (o_block_cnt)
`endif
    );

    always #5 i_clk = ~i_clk;

    // Position p (1 = MSB) of an n-bit value, output assembled MSB first
    function automatic int pm(int v, int n, int t[10], int m);
        int o = 0;
        for (int i = 0; i < m; i++) o = (o << 1) | ((v >> (n - t[i])) & 1);
        return o;
    endfunction

    function automatic int rot5(int x, int s);
        return ((x << s) | (x >> (5 - s))) & 31;
    endfunction

    function automatic int ff(int rr, int k);
        int e = pm(rr, 4, EP, 8) ^ k;
        int a = e >> 4;
        int b = e & 15;
        int v0 = S0[(((a >> 3) & 1) * 2 + (a & 1)) * 4 + ((a >> 1) & 3)];
        int v1 = S1[(((b >> 3) & 1) * 2 + (b & 1)) * 4 + ((b >> 1) & 3)];
        return pm((v0 << 2) | v1, 4, P4, 4);
    endfunction

    function automatic int sdes(int key, int blk, bit dec);
        int p = pm(key, 10, P10, 10);
        int hl = p >> 5;
        int hr = p & 31;
        int k1 = pm((rot5(hl, 1) << 5) | rot5(hr, 1), 10, P8, 8);
        int k2 = pm((rot5(hl, 3) << 5) | rot5(hr, 3), 10, P8, 8);
        int x = pm(blk, 8, IP, 8);
        int lh = x >> 4;
        int rh = x & 15;
        int t;
        lh = lh ^ ff(rh, dec ? k2 : k1);
        t = lh; lh = rh; rh = t;
        lh = lh ^ ff(rh, dec ? k1 : k2);
        return pm((lh << 4) | rh, 8, IPI, 8);
    endfunction

    task automatic chk(string nm, int act, int expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    task automatic timeout(string nm);
        total++;
        bad++;
        $display("FAIL %s: bound expired", nm);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send(int k, int b, bit d);
        int t = 0;
        while (!o_ready && t < 50) begin step(); t++; end
        if (!o_ready) timeout("send_ready");
        i_key = k[9:0]; i_block = b[7:0]; i_decrypt = d; i_valid = 1'b1;
        exp_q.push_back(sdes(k, b, d));
        step();
        i_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || !o_ready) && t < 100) begin step(); t++; end
        if (t >= 100) timeout("wait_idle");
    endtask

    // Monitor: every result handshake pops the oldest expected block
    always @(negedge i_clk) begin
        if (!i_rst && o_valid && i_ready) begin
            if (exp_q.size() == 0) timeout("unexpected_result");
            else chk("result", int'(o_block), exp_q.pop_front());
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, last, cyc, held;
        i_rst = 1'b1; i_valid = 1'b0; i_decrypt = 1'b0; i_key = '0; i_block = '0; i_ready = 1'b1;
        #12;
        chk("rst_valid", int'(o_valid), 0);
        chk("rst_block", int'(o_block), 0);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_ready", int'(o_ready), 1);
        @(posedge i_clk); #1; i_rst = 1'b0;
        step();

        send(10'b1010000010, 8'b01110010, 1'b0);
        chk("keygen_busy", int'(o_busy), 1);
        chk("keygen_ready", int'(o_ready), 0);
        step();
        chk("k1", int'(dut.k1), 8'b10100100);
        chk("k2", int'(dut.k2), 8'b01000011);
        chk("lat1_valid", int'(o_valid), 0);
        step();
        chk("lat2_valid", int'(o_valid), 0);
        step();
        chk("lat3_valid", int'(o_valid), 1);
        chk("enc_block", int'(o_block), 8'b01110111);
        wait_idle();

        send(10'b1010000010, 8'b01110111, 1'b1);
        step(); step(); step();
        chk("dec_block", int'(o_block), 8'b01110010);
        wait_idle();

        i_ready = 1'b0;
        send(10'h2C7, 8'h5A, 1'b0);
        step(); step(); step();
        held = sdes(10'h2C7, 8'h5A, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", int'(o_valid), 1);
            chk("bp_block", int'(o_block), held);
            chk("bp_ready", int'(o_ready), 0);
            i_valid = (i == 2);
            i_key = 10'h155; i_block = 8'hC3;
            step();
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        step();
        chk("bp_rel_valid", int'(o_valid), 0);
        chk("bp_rel_ready", int'(o_ready), 1);
        step();
        chk("bp_no_accept", int'(o_busy), 0);

        send(10'h3FF, 8'hFF, 1'b0);
        step();
        i_rst = 1'b1;
        #1;
        chk("abort_valid", int'(o_valid), 0);
        chk("abort_block", int'(o_block), 0);
        chk("abort_busy", int'(o_busy), 0);
        exp_q.delete();
        step();
        i_rst = 1'b0;
        step();
        send(0, 0, 1'b0);
        wait_idle();

        acc = 0; last = 0; cyc = 0;
        i_key = 10'($urandom); i_block = 8'($urandom); i_decrypt = 1'($urandom);
        i_valid = 1'b1;
        while (acc < 3 && cyc < 60) begin
            if (o_ready) begin
                exp_q.push_back(sdes(i_key, i_block, i_decrypt));
                if (acc > 0) chk("b2b_busy_cycles", cyc - last - 1, 4);
                last = cyc;
                acc++;
                step(); cyc++;
                i_key = 10'($urandom); i_block = 8'($urandom); i_decrypt = 1'($urandom);
            end else begin
                if (o_valid && acc == 0) timeout("b2b_state");
                step(); cyc++;
            end
        end
        i_valid = 1'b0;
        if (acc < 3) timeout("b2b_accepts");
        wait_idle();

        for (int n = 0; n < 20; n++) begin
            int t = 0;
            send($urandom_range(0, 1023), $urandom_range(0, 255), 1'($urandom));
            while (exp_q.size() != 0 && t < 60) begin
                i_ready = 1'($urandom);
                step(); t++;
            end
            i_ready = 1'b1;
            wait_idle();
        end

`ifdef SDES_BLOCK_CNT_EN
        i_rst = 1'b1; step(); i_rst = 1'b0; step();
        for (int n = 0; n < 3; n++) begin
            send($urandom_range(0, 1023), $urandom_range(0, 255), 1'($urandom));
            wait_idle();
        end
        chk("cnt_three", int'(o_block_cnt), 3);
        force dut.o_block_cnt = 16'hFFFF;
        #1;
        release dut.o_block_cnt;
        send($urandom_range(0, 1023), $urandom_range(0, 255), 1'b0);
        wait_idle();
        chk("cnt_wrap", int'(o_block_cnt), 0);
`endif

        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
